// File: rtl/sha512_pkg.sv
// sha512_pkg: shared widths, FSM encoding and IV constants for the SHA-512 message controller.
package sha512_pkg;

    typedef logic [1023:0] chunk_t;
    typedef logic [511:0]  hash_t;
    typedef logic [511:0]  digest_t;

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_GUARD, ST_RUN, ST_OUT} state_e;

    localparam hash_t SHA512_IV = {
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };

    localparam hash_t SHA384_IV = {
        64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
        64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4
    };

endpackage

// File: rtl/sha512_msg_ctrl_if.sv
// sha512_msg_ctrl_if: chunk input stream and digest output stream; in_mode exists only with SHA512_CTRL_384_EN.
interface sha512_msg_ctrl_if;
    import sha512_pkg::*;

    logic    in_valid;
    logic    in_ready;
    chunk_t  in_chunk;
    logic    in_last;
    logic    out_valid;
    logic    out_ready;
    digest_t out_digest;

`ifdef SHA512_CTRL_384_EN
    logic    in_mode;

    modport master (output in_valid, in_chunk, in_last, in_mode, out_ready,
                    input  in_ready, out_valid, out_digest);
    modport slave  (input  in_valid, in_chunk, in_last, in_mode, out_ready,
                    output in_ready, out_valid, out_digest);
`else
    modport master (output in_valid, in_chunk, in_last, out_ready,
                    input  in_ready, out_valid, out_digest);
    modport slave  (input  in_valid, in_chunk, in_last, out_ready,
                    output in_ready, out_valid, out_digest);
`endif

endinterface

// File: rtl/sha512_msg_ctrl.sv
// sha512_msg_ctrl: sequences one external sha512_chunk core across multi-chunk messages,
// chaining each chunk's output hash into the next. Define SHA512_CTRL_384_EN for SHA-384 mode.
module sha512_msg_ctrl
    import sha512_pkg::*;
#(
    parameter hash_t IV = SHA512_IV
) (
    input  logic             clk,
    input  logic             reset,
    sha512_msg_ctrl_if.slave bus,
    output logic [15:0]      msg_chunks_o,
    output logic             core_reset_o,
    output chunk_t           core_chunk_o,
    output hash_t            core_ih_o,
    input  logic             core_done_i,
    input  hash_t            core_oh_i
);

    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_START = ST_START;
    localparam logic [2:0] S_GUARD = ST_GUARD;
    localparam logic [2:0] S_RUN   = ST_RUN;
    localparam logic [2:0] S_OUT   = ST_OUT;

    logic [2:0]  state_q, state_d;
    hash_t       h_q, h_d;
    chunk_t      chunk_q, chunk_d;
    logic        last_q, last_d;
    logic [15:0] cnt_q, cnt_d;
    logic        core_reset_q;
`ifdef SHA512_CTRL_384_EN
    logic        mode_q, mode_d;
`endif

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_OUT);
`ifdef SHA512_CTRL_384_EN
    assign bus.out_digest = {h_q[511:128], mode_q ? 128'b0 : h_q[127:0]};
`else
    assign bus.out_digest = h_q;
`endif
    assign msg_chunks_o = cnt_q;
    assign core_reset_o = core_reset_q;
    assign core_chunk_o = chunk_q;
    assign core_ih_o    = h_q;

    // Next-state: accept, restart core, mask stale done for one cycle, capture result, hand off digest
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        chunk_d = chunk_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
`ifdef SHA512_CTRL_384_EN
        mode_d  = mode_q;
`endif
        case (state_q)
            S_IDLE: if (bus.in_valid) begin
                chunk_d = bus.in_chunk;
                last_d  = bus.in_last;
                state_d = S_START;
`ifdef SHA512_CTRL_384_EN
                if (cnt_q == 16'd0) begin
                    mode_d = bus.in_mode;
                    h_d    = bus.in_mode ? SHA384_IV : IV;
                end
`endif
            end
            S_START: state_d = S_GUARD;
            S_GUARD: state_d = S_RUN;
            S_RUN: if (core_done_i) begin
                h_d     = core_oh_i;
                cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                state_d = last_q ? S_OUT : S_IDLE;
            end
            S_OUT: if (bus.out_ready) begin
                h_d     = IV;
                cnt_d   = 16'd0;
                state_d = S_IDLE;
`ifdef SHA512_CTRL_384_EN
                mode_d  = 1'b0;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; core_reset is registered from the next state so it is high exactly during START
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            h_q          <= IV;
            chunk_q      <= '0;
            last_q       <= 1'b0;
            cnt_q        <= 16'd0;
            core_reset_q <= 1'b1;
`ifdef SHA512_CTRL_384_EN
            mode_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            h_q          <= h_d;
            chunk_q      <= chunk_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            core_reset_q <= (state_d == S_START);
`ifdef SHA512_CTRL_384_EN
            mode_q       <= mode_d;
`endif
        end
    end

endmodule

// File: tb/tb_sha512_msg_ctrl.sv
// tb_sha512_msg_ctrl: scoreboard bench for sha512_msg_ctrl with a behavioural SHA-512 core of configurable latency.
module tb_sha512_msg_ctrl;

    localparam logic [511:0] IV512 = {
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };
    localparam logic [511:0] ABC_D = 512'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f;
    localparam logic [511:0] NIST_D = 512'h8e959b75dae313da8cf4f72814fc143f8f7779c6eb9f7fa17299aeadb6889018501d289e4900f7e4331b99dec4b5433ac7d329eeb6dd26545e96e55b874be909;
`ifdef SHA512_CTRL_384_EN
    localparam logic [511:0] ABC384_D = {384'hcb00753f45a35e8bb5a03d699ac65007272c32ab0eded1631a8b605a43ff5bed8086072ba1e7cc2358baeca134c825a7, 128'h0};
`endif

    localparam logic [63:0] K [80] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    typedef struct {
        logic [511:0] dig;
        logic [15:0]  n;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [15:0]    msg_chunks;
    logic           core_reset;
    logic [1023:0]  core_chunk;
    logic [511:0]   core_ih;
    logic           core_done = 1'b0;
    logic [511:0]   core_oh = '0;

    int             errors = 0;
    int             checks = 0;
    int             lat = 4;
    int             m_cnt = 0;
    logic           m_pend = 1'b0;
    logic           stale_mode = 1'b0;
    logic [1023:0]  m_chunk = '0;
    logic [511:0]   m_ih = '0;
    logic           sent2 = 1'b0;
    exp_t           sbq[$];
    exp_t           mon_e;

    sha512_msg_ctrl_if bus();

    sha512_msg_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .msg_chunks_o (msg_chunks),
        .core_reset_o (core_reset),
        .core_chunk_o (core_chunk),
        .core_ih_o    (core_ih),
        .core_done_i  (core_done),
        .core_oh_i    (core_oh)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Reference SHA-512 compression of one chunk, including the final feed-forward addition
    function automatic logic [511:0] compress(input logic [511:0] ih, input logic [1023:0] c);
        logic [63:0] w [80];
        logic [63:0] a, b, cc, d, e, f, g, h, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = c[1023 - 64*i -: 64];
        for (int i = 16; i < 80; i++) begin
            s0 = ror(w[i-15], 1) ^ ror(w[i-15], 8) ^ (w[i-15] >> 7);
            s1 = ror(w[i-2], 19) ^ ror(w[i-2], 61) ^ (w[i-2] >> 6);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, cc, d, e, f, g, h} = ih;
        for (int i = 0; i < 80; i++) begin
            t1 = h + (ror(e, 14) ^ ror(e, 18) ^ ror(e, 41)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (ror(a, 28) ^ ror(a, 34) ^ ror(a, 39)) + ((a & b) ^ (a & cc) ^ (b & cc));
            h = g; g = f; f = e; e = d + t1; d = cc; cc = b; b = a; a = t1 + t2;
        end
        return {ih[511:448] + a, ih[447:384] + b, ih[383:320] + cc, ih[319:256] + d,
                ih[255:192] + e, ih[191:128] + f, ih[127:64] + g, ih[63:0] + h};
    endfunction

    function automatic logic [1023:0] abc_chunk();
        logic [1023:0] c = '0;
        c[1023:992] = 32'h61626380;
        c[127:0]    = 128'd24;
        return c;
    endfunction

    function automatic logic [1023:0] nist1_chunk();
        logic [1023:0] c = '0;
        for (int i = 0; i < 14; i++)
            for (int j = 0; j < 8; j++)
                c[1023 - 64*i - 8*j -: 8] = 8'(97 + i + j);
        c[127:120] = 8'h80;
        return c;
    endfunction

    function automatic logic [1023:0] nist2_chunk();
        logic [1023:0] c = '0;
        c[127:0] = 128'd896;
        return c;
    endfunction

    // Behavioural core: restarts on core_reset, optionally keeps a poisoned stale done high for one more cycle
    always @(posedge clk) begin
        if (core_reset) begin
            m_pend    <= 1'b1;
            m_cnt     <= lat;
            m_chunk   <= core_chunk;
            m_ih      <= core_ih;
            core_done <= stale_mode;
            if (stale_mode) core_oh <= {8{64'h5555555555555555}};
        end else if (m_pend) begin
            if (m_cnt == 0) begin
                core_done <= 1'b1;
                core_oh   <= compress(m_ih, m_chunk);
                m_pend    <= 1'b0;
            end else begin
                core_done <= 1'b0;
                m_cnt     <= m_cnt - 1;
            end
        end
    end

    // Monitor: every digest handshake must match the oldest expected entry
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_digest: got %h chunks=%0d with nothing expected", bus.out_digest, msg_chunks);
            end else begin
                mon_e = sbq.pop_front();
                if (bus.out_digest !== mon_e.dig || msg_chunks !== mon_e.n) begin
                    errors++;
                    $display("FAIL digest: got %h chunks=%0d expected %h chunks=%0d", bus.out_digest, msg_chunks, mon_e.dig, mon_e.n);
                end
            end
        end
    end

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_digest(input logic [511:0] d, input logic [15:0] n);
        exp_t e;
        e.dig = d;
        e.n   = n;
        sbq.push_back(e);
    endtask

    // Offer one chunk and hold it until accepted; called just after a rising edge
    task automatic send(input logic [1023:0] c, input logic last);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_chunk = c;
        bus.in_last  = last;
        @(negedge clk);
        while (!bus.in_ready && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready still 0 after %0d cycles", t);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sbq.size() != 0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d digests outstanding", sbq.size());
            sbq.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        bus.in_valid  = 1'b0;
        bus.in_chunk  = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
`ifdef SHA512_CTRL_384_EN
        bus.in_mode   = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 512'(bus.in_ready), 512'd1);
        check("rst_out_valid", 512'(bus.out_valid), 512'd0);
        check("rst_out_digest", bus.out_digest, IV512);
        check("rst_msg_chunks", 512'(msg_chunks), 512'd0);
        check("rst_core_reset", 512'(core_reset), 512'd1);
        check("rst_core_chunk_hi", core_chunk[1023:512], 512'd0);
        check("rst_core_chunk_lo", core_chunk[511:0], 512'd0);
        check("rst_core_ih", core_ih, IV512);
        @(posedge clk);
        #1;
        reset = 1'b0;

        lat = 4;
        expect_digest(ABC_D, 16'd1);
        send(abc_chunk(), 1'b1);
        @(negedge clk);
        check("start_core_reset", 512'(core_reset), 512'd1);
        check("start_in_ready", 512'(bus.in_ready), 512'd0);
        check("start_core_chunk_hi", core_chunk[1023:512], 512'h61626380 << 480);
        check("start_core_ih", core_ih, IV512);
        @(negedge clk);
        check("guard_core_reset", 512'(core_reset), 512'd0);
        drain();
        @(negedge clk);
        check("post_msg_chunks", 512'(msg_chunks), 512'd0);
        check("post_out_valid", 512'(bus.out_valid), 512'd0);
        check("post_core_ih", core_ih, IV512);
        @(posedge clk);
        #1;

        lat = 9;
        expect_digest(NIST_D, 16'd2);
        send(nist1_chunk(), 1'b0);
        send(nist2_chunk(), 1'b1);
        drain();

        lat = 3;
        bus.out_ready = 1'b0;
        expect_digest(ABC_D, 16'd1);
        expect_digest(ABC_D, 16'd1);
        send(abc_chunk(), 1'b1);
        sent2 = 1'b0;
        fork
            begin
                send(abc_chunk(), 1'b1);
                sent2 = 1'b1;
            end
        join_none
        t = 0;
        while (!bus.out_valid && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("bp_out_valid_seen", 512'(bus.out_valid), 512'd1);
        repeat (50) begin
            @(negedge clk);
            check("bp_digest_stable", bus.out_digest, ABC_D);
            check("bp_out_valid_held", 512'(bus.out_valid), 512'd1);
            check("bp_in_ready_low", 512'(bus.in_ready), 512'd0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        t = 0;
        while (!sent2 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("bp_second_accepted", 512'(sent2), 512'd1);
        @(posedge clk);
        #1;
        drain();

        lat = 6;
        stale_mode = 1'b1;
        expect_digest(ABC_D, 16'd1);
        send(abc_chunk(), 1'b1);
        drain();
        stale_mode = 1'b0;

        lat = 20;
        send(nist1_chunk(), 1'b0);
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("abort_out_valid", 512'(bus.out_valid), 512'd0);
        check("abort_core_reset", 512'(core_reset), 512'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_msg_chunks", 512'(msg_chunks), 512'd0);
        check("abort_core_ih", core_ih, IV512);
        check("abort_in_ready", 512'(bus.in_ready), 512'd1);
        @(posedge clk);
        #1;
        lat = 5;
        expect_digest(ABC_D, 16'd1);
        send(abc_chunk(), 1'b1);
        drain();

`ifdef SHA512_CTRL_384_EN
        lat = 3;
        bus.in_mode = 1'b1;
        expect_digest(ABC384_D, 16'd1);
        send(abc_chunk(), 1'b1);
        bus.in_mode = 1'b0;
        drain();
        expect_digest(ABC_D, 16'd1);
        send(abc_chunk(), 1'b1);
        drain();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sha512_msg_ctrl.md
# sha512_msg_ctrl

Sequences one external `sha512_chunk` compression core across multi-chunk messages. It accepts pre-padded 1024-bit chunks over a valid/ready stream and chains each chunk's output hash into the next chunk's input hash. When the last chunk finishes, it presents the 512-bit digest on a valid/ready output. It sits between the padding/stream front end and the compression core, and owns every restart of the core.

## Interface
- `IV` (default: SHA-512 initial hash, 8×64-bit, H0 first) — chaining value loaded at the start of each message.
- `clk`  in  1  — single clock; all state is in this domain.
- `reset`  in  1  — asynchronous, active-high; clears all state.
- `in_valid`  in  1  — a chunk is offered.
- `in_ready`  out  1  — the controller can accept a chunk.
- `in_chunk`  in  1024  — padded chunk; word 0 is in bits [1023:960].
- `in_last`  in  1  — this chunk ends the message.
- `out_valid`  out  1  — `out_digest` is valid.
- `out_ready`  in  1  — consumer accepts the digest.
- `out_digest`  out  512  — final hash, H0 in [511:448].
- `msg_chunks`  out  16  — number of chunks completed in the current message.
- `core_reset`  out  1  — restart pulse to the core.
- `core_chunk`  out  1024  — registered chunk presented to the core.
- `core_iH`  out  512  — registered chaining value presented to the core.
- `core_done`  in  1  — core has finished compression.
- `core_oH`  in  512  — core output hash; valid while `core_done` is high.

## Operation
- **States:** IDLE, START, GUARD, RUN, OUT.
- **IDLE:**
  - `in_ready` = 1.
  - On `in_valid`: latch `in_chunk` into `core_chunk` and `in_last` into `last_r`; go to START.
- **START:** `core_reset` = 1 for exactly this cycle; go to GUARD.
- **GUARD:**
  - One cycle in which `core_done` is ignored, because a stale done from the previous run may still be high.
  - Go to RUN.
- **RUN:** wait for `core_done`. In the cycle it is high:
  - `H` <= `core_oH`.
  - `msg_chunks` increments.
  - Go to OUT if `last_r` is set, otherwise go to IDLE.
- **OUT:**
  - `out_valid` = 1 and `out_digest` = `H`.
  - On `out_ready`: `H` <= `IV`, `msg_chunks` <= 0, go to IDLE.
- **Chaining:**
  - `core_iH` always reflects `H`.
  - `H` equals `IV` at the start of a message and the previous `core_oH` afterwards. The 64-bit additions are performed inside the core; the controller adds nothing.
- **`msg_chunks`:** saturates at 16'hFFFF; it never wraps.
- **Ready signals:**
  - `in_ready` is low in every state except IDLE; chunks are never buffered.
  - `out_ready` is ignored outside OUT.
  - A chunk offered during OUT stalls until the digest handshake completes.
- **Reset:**
  - Asserting `reset` at any point aborts the message: state IDLE, `H` = `IV`, counters zeroed.
  - `core_reset` is forced high while `reset` is asserted.
  - A partial hash is never emitted.

## Timing
- **Reset values:**
  - `in_ready` = 1, `out_valid` = 0, `out_digest` = `IV`, `msg_chunks` = 0.
  - `core_reset` = 1, `core_chunk` = 0, `core_iH` = `IV`.
- **Per-chunk sequence:** accept at cycle N; `core_reset` high at N+1; GUARD at N+2; `core_done` first sampled at N+3.
- **Completion:** if `core_done` is first seen at cycle D, then at D+1 either `in_ready` = 1 (more chunks) or `out_valid` = 1 (last chunk).
- **Controller overhead:** 3 cycles per chunk plus the core latency. The next chunk can be accepted in the same cycle `in_ready` rises.
- **Output stability:** `out_valid` and `out_digest` hold stable until the handshake; `out_valid` falls the cycle after `out_ready`.
- **Registered outputs:** all outputs are registers except `in_ready`, `out_valid` and `out_digest`, which are decoded from registered state and `H`.

## Configuration
- **`SHA512_CTRL_384_EN` defined:**
  - Adds input port `in_mode` (1 bit), sampled with the first chunk of each message.
  - `in_mode` = 1 selects the SHA-384 IV for that message, and `out_digest[127:0]` is forced to 0 (the truncated digest sits in [511:128]).
  - `in_mode` is ignored on non-first chunks.
- **Not defined:** no `in_mode` port; SHA-512 only.

## Structure
- **Shared package `sha512_pkg`:**
  - State enum.
  - SHA-512 and SHA-384 IV constants.
  - Chunk, hash and digest width typedefs.
- **No sub-modules.** The `sha512_chunk` core is instantiated alongside this block at the level above; the bench supplies a behavioural core model with configurable latency.

## Test plan
- **Single chunk "abc"** (0x616263 padded, `in_last` = 1) → `out_digest` = ddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f, `msg_chunks` = 1.
- **Two-chunk 896-bit NIST message** ("abcdefghbcdefghi…nopqrstu") → digest 8e959b75dae313da8cf4f72814fc143f8f7779c6eb9f7fa17299aeadb6889018501d289e4900f7e4331b99dec4b5433ac7d329eeb6dd26545e96e55b874be909, `msg_chunks` = 2.
- **Back-pressure:**
  - Hold `out_ready` = 0 for 50 cycles → digest stable throughout, `in_ready` = 0.
  - Offer a second "abc" message meanwhile → accepted only after the handshake; second digest identical to the first.
- **Stale done:** model holds `core_done` = 1 across the restart → GUARD masks it; `H` captures only the new result; digest correct.
- **Mid-run reset:** assert `reset` mid-RUN of chunk 1 of the two-chunk message, then send "abc" → `out_valid` stays 0 during the aborted message; "abc" digest correct.
- **With `SHA512_CTRL_384_EN`:** `in_mode` = 1, "abc" → `out_digest[511:128]` = cb00753f45a35e8bb5a03d699ac65007272c32ab0eded1631a8b605a43ff5bed8086072ba1e7cc2358baeca134c825a7, `[127:0]` = 0.
